// File: rtl/hilo_acc_reg.sv
// HI/LO special-register pair with direct writes and a two-cycle 2W-bit accumulate.
// The low half is summed on the accepting edge and the high half with carry on the next edge.
module hilo_acc_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [2:0]   op_mode,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o,
  output logic         busy,
  output logic         ovf
);

  typedef enum logic {StIdle, StAccHi} state_e;

  localparam logic [2:0] OpNop    = 3'd0;
  localparam logic [2:0] OpWrBoth = 3'd1;
  localparam logic [2:0] OpWrHi   = 3'd2;
  localparam logic [2:0] OpWrLo   = 3'd3;
  localparam logic [2:0] OpAccAdd = 3'd4;
  localparam logic [2:0] OpAccSub = 3'd5;
  localparam logic [2:0] OpClear  = 3'd6;

  state_e         r_state, w_state_nxt;
  logic [W-1:0]   r_hi, w_hi_nxt;
  logic [W-1:0]   r_lo, w_lo_nxt;
  logic           r_ovf, w_ovf_nxt;
  logic [W-1:0]   r_lo_sum, w_lo_sum_nxt;
  logic           r_c, w_c_nxt;
  logic [W-1:0]   r_b_hi, w_b_hi_nxt;
  logic           r_sign, w_sign_nxt;
  logic           r_sub, w_sub_nxt;

  logic           w_sub;
  logic [W-1:0]   w_b_lo;
  logic [W-1:0]   w_b_hi;
  logic [W:0]     w_lo_add;
  logic [W-1:0]   w_hi_new;
  logic           w_ovf_acc;

  // Subtraction is two's complement: invert the operand and inject a carry into the low half.
  assign w_sub    = (op_mode == OpAccSub);
  assign w_b_lo   = lo_i ^ {W{w_sub}};
  assign w_b_hi   = hi_i ^ {W{w_sub}};
  assign w_lo_add = {1'b0, r_lo} + {1'b0, w_b_lo} + {{W{1'b0}}, w_sub};
  assign w_hi_new = r_hi + r_b_hi + {{(W-1){1'b0}}, r_c};

  always_comb begin
    w_ovf_acc = 1'b0;
    if (w_hi_new[W-1] != r_hi[W-1]) begin
      w_ovf_acc = r_sub ? (r_hi[W-1] != r_sign) : (r_hi[W-1] == r_sign);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_ovf_nxt    = r_ovf;
    w_lo_sum_nxt = r_lo_sum;
    w_c_nxt      = r_c;
    w_b_hi_nxt   = r_b_hi;
    w_sign_nxt   = r_sign;
    w_sub_nxt    = r_sub;
    unique case (r_state)
      StIdle: begin
        if (op_valid) begin
          case (op_mode)
            OpWrBoth: begin
              w_hi_nxt  = hi_i;
              w_lo_nxt  = lo_i;
              w_ovf_nxt = 1'b0;
            end
            OpWrHi: w_hi_nxt = hi_i;
            OpWrLo: w_lo_nxt = lo_i;
            OpAccAdd, OpAccSub: begin
              w_lo_sum_nxt = w_lo_add[W-1:0];
              w_c_nxt      = w_lo_add[W];
              w_b_hi_nxt   = w_b_hi;
              w_sign_nxt   = hi_i[W-1];
              w_sub_nxt    = w_sub;
              w_state_nxt  = StAccHi;
            end
            OpClear: begin
              w_hi_nxt  = '0;
              w_lo_nxt  = '0;
              w_ovf_nxt = 1'b0;
            end
            OpNop:   ;
            default: ;
          endcase
        end
      end
      StAccHi: begin
        // Both halves commit together so a half-updated pair is never visible.
        w_hi_nxt    = w_hi_new;
        w_lo_nxt    = r_lo_sum;
        w_ovf_nxt   = r_ovf | w_ovf_acc;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_hi     <= '0;
      r_lo     <= '0;
      r_ovf    <= 1'b0;
      r_lo_sum <= '0;
      r_c      <= 1'b0;
      r_b_hi   <= '0;
      r_sign   <= 1'b0;
      r_sub    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_ovf    <= w_ovf_nxt;
      r_lo_sum <= w_lo_sum_nxt;
      r_c      <= w_c_nxt;
      r_b_hi   <= w_b_hi_nxt;
      r_sign   <= w_sign_nxt;
      r_sub    <= w_sub_nxt;
    end
  end

  assign op_ready = (r_state == StIdle);
  assign busy     = (r_state == StAccHi);
  assign hi_o     = r_hi;
  assign lo_o     = r_lo;
  assign ovf      = r_ovf;

endmodule
